// File: rtl/awb_gain_apply.sv
// Gray-world auto white balance: derives G/R and G/B gains from per-frame
// channel means with a serial restoring divider, commits them between frames,
// and applies them to a 2-stage tagged pixel pipeline.
module awb_gain_apply #(
    parameter int FRAC   = 6,
    parameter int GAIN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mean_valid_i,
    input  logic [7:0]        r_mean_i,
    input  logic [7:0]        g_mean_i,
    input  logic [7:0]        b_mean_i,
    input  logic              valid_i,
    input  logic [1:0]        color_i,
    input  logic [7:0]        value_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic [1:0]        color_o,
    output logic [7:0]        value_o,
    output logic              last_o,
    output logic              busy_o,
    output logic [GAIN_W-1:0] gain_r_o,
    output logic [GAIN_W-1:0] gain_b_o
);

    localparam int DW    = 8 + FRAC;
    localparam int CNT_W = $clog2(DW);
    localparam int PW    = 8 + GAIN_W;
    localparam int SW    = PW + 1 - FRAC;
    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(1 << FRAC);
    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
    localparam logic [PW:0]       RND      = (PW + 1)'(1 << (FRAC - 1));
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DW - 1);

    typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, LOAD} state_t;

    state_t            state_q, state_d;
    logic [7:0]        r_mean_q, r_mean_d, g_mean_q, g_mean_d, b_mean_q, b_mean_d;
    logic [7:0]        rem_q, rem_d;
    logic [DW-1:0]     quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAIN_W-1:0] qr_q, qr_d, qb_q, qb_d;
    logic [GAIN_W-1:0] pend_r_q, pend_r_d, pend_b_q, pend_b_d;
    logic              pend_flag_q, pend_flag_d;
    logic [GAIN_W-1:0] gain_r_q, gain_r_d, gain_b_q, gain_b_d;
    logic              in_frame_q, in_frame_d;

    logic              valid_s1_q, valid_s1_d, last_s1_q, last_s1_d;
    logic [1:0]        color_s1_q, color_s1_d;
    logic [7:0]        value_s1_q, value_s1_d;
    logic [GAIN_W-1:0] gain_s1_q, gain_s1_d;
    logic              valid_o_q, valid_o_d, last_o_q, last_o_d;
    logic [1:0]        color_o_q, color_o_d;
    logic [7:0]        value_o_q, value_o_d;

    logic [7:0]        divisor;
    logic [8:0]        rem_sh;
    logic              take;
    logic [DW-1:0]     quo_nx;
    logic [GAIN_W-1:0] q_sat;
    logic [PW-1:0]     prod;
    logic [PW:0]       rounded;
    logic [SW-1:0]     scaled;

    // Divider datapath: one restoring step per cycle plus saturation of the finished quotient
    always_comb begin
        divisor = (state_q == DIV_B) ? b_mean_q : r_mean_q;
        rem_sh  = {rem_q, quo_q[DW-1]};
        take    = (rem_sh >= {1'b0, divisor});
        quo_nx  = {quo_q[DW-2:0], take};
        // a zero divisor forces the maximum gain regardless of the quotient bits
        if (divisor == '0 || |quo_nx[DW-1:GAIN_W]) q_sat = GAIN_MAX;
        else                                       q_sat = quo_nx[GAIN_W-1:0];
    end

    // Control: frame tracking, gain commit between frames, and the divide sequencer
    always_comb begin
        state_d     = state_q;
        r_mean_d    = r_mean_q;
        g_mean_d    = g_mean_q;
        b_mean_d    = b_mean_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        qr_d        = qr_q;
        qb_d        = qb_q;
        pend_r_d    = pend_r_q;
        pend_b_d    = pend_b_q;
        pend_flag_d = pend_flag_q;
        gain_r_d    = gain_r_q;
        gain_b_d    = gain_b_q;
        in_frame_d  = in_frame_q;

        if (valid_i) in_frame_d = !last_i;

        if (pend_flag_q && !in_frame_q && !valid_i) begin
            gain_r_d    = pend_r_q;
            gain_b_d    = pend_b_q;
            pend_flag_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (mean_valid_i) begin
                    r_mean_d = r_mean_i;
                    g_mean_d = g_mean_i;
                    b_mean_d = b_mean_i;
                    rem_d    = '0;
                    quo_d    = {g_mean_i, {FRAC{1'b0}}};
                    cnt_d    = '0;
                    state_d  = DIV_R;
                end
            end
            DIV_R, DIV_B: begin
                rem_d = take ? 8'(rem_sh - {1'b0, divisor}) : rem_sh[7:0];
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (state_q == DIV_R) begin
                        qr_d    = q_sat;
                        rem_d   = '0;
                        quo_d   = {g_mean_q, {FRAC{1'b0}}};
                        state_d = DIV_B;
                    end else begin
                        qb_d    = q_sat;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                // a fresh result supersedes any commit happening this same cycle
                pend_r_d    = qr_q;
                pend_b_d    = qb_q;
                pend_flag_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel pipeline: stage 1 samples inputs and the per-colour gain, stage 2 scales and clips
    always_comb begin
        valid_s1_d = valid_i;
        last_s1_d  = valid_i & last_i;
        color_s1_d = color_i;
        value_s1_d = value_i;
        unique case (color_i)
            2'd0:    gain_s1_d = gain_r_q;
            2'd2:    gain_s1_d = gain_b_q;
            default: gain_s1_d = UNITY;
        endcase

        prod    = {{GAIN_W{1'b0}}, value_s1_q} * {8'b0, gain_s1_q};
        rounded = {1'b0, prod} + RND;
        scaled  = rounded[PW:FRAC];

        valid_o_d = valid_s1_q;
        last_o_d  = last_s1_q;
        color_o_d = color_s1_q;
        value_o_d = value_o_q;
        if (valid_s1_q) begin
            if (color_s1_q == 2'd3)     value_o_d = value_s1_q;
            else if (|scaled[SW-1:8])   value_o_d = 8'hFF;
            else                        value_o_d = scaled[7:0];
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_mean_q    <= '0;
            g_mean_q    <= '0;
            b_mean_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            qr_q        <= '0;
            qb_q        <= '0;
            pend_r_q    <= '0;
            pend_b_q    <= '0;
            pend_flag_q <= 1'b0;
            gain_r_q    <= UNITY;
            gain_b_q    <= UNITY;
            in_frame_q  <= 1'b0;
            valid_s1_q  <= 1'b0;
            last_s1_q   <= 1'b0;
            color_s1_q  <= '0;
            value_s1_q  <= '0;
            gain_s1_q   <= '0;
            valid_o_q   <= 1'b0;
            last_o_q    <= 1'b0;
            color_o_q   <= '0;
            value_o_q   <= '0;
        end else begin
            state_q     <= state_d;
            r_mean_q    <= r_mean_d;
            g_mean_q    <= g_mean_d;
            b_mean_q    <= b_mean_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            qr_q        <= qr_d;
            qb_q        <= qb_d;
            pend_r_q    <= pend_r_d;
            pend_b_q    <= pend_b_d;
            pend_flag_q <= pend_flag_d;
            gain_r_q    <= gain_r_d;
            gain_b_q    <= gain_b_d;
            in_frame_q  <= in_frame_d;
            valid_s1_q  <= valid_s1_d;
            last_s1_q   <= last_s1_d;
            color_s1_q  <= color_s1_d;
            value_s1_q  <= value_s1_d;
            gain_s1_q   <= gain_s1_d;
            valid_o_q   <= valid_o_d;
            last_o_q    <= last_o_d;
            color_o_q   <= color_o_d;
            value_o_q   <= value_o_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign gain_r_o = gain_r_q;
    assign gain_b_o = gain_b_q;
    assign valid_o  = valid_o_q;
    assign last_o   = last_o_q;
    assign color_o  = color_o_q;
    assign value_o  = value_o_q;

endmodule

// File: tb/tb_awb_gain_apply.sv
// Directed bench for awb_gain_apply: gain derivation, pixel scaling table,
// zero divisor, mid-frame gain deferral, dropped strobes and reset abort.
module tb_awb_gain_apply;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mean_valid_i;
    logic [7:0] r_mean_i, g_mean_i, b_mean_i;
    logic       valid_i;
    logic [1:0] color_i;
    logic [7:0] value_i;
    logic       last_i;
    logic       valid_o;
    logic [1:0] color_o;
    logic [7:0] value_o;
    logic       last_o;
    logic       busy_o;
    logic [7:0] gain_r_o, gain_b_o;

    int n_total = 0;
    int n_pass  = 0;

    awb_gain_apply #(.FRAC(6), .GAIN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mean_valid_i(mean_valid_i),
        .r_mean_i(r_mean_i), .g_mean_i(g_mean_i), .b_mean_i(b_mean_i),
        .valid_i(valid_i), .color_i(color_i), .value_i(value_i), .last_i(last_i),
        .valid_o(valid_o), .color_o(color_o), .value_o(value_o), .last_o(last_o),
        .busy_o(busy_o), .gain_r_o(gain_r_o), .gain_b_o(gain_b_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] color;
        logic [7:0] value;
        logic       last;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic strobe(input int r, input int g, input int b);
        r_mean_i     = 8'(r);
        g_mean_i     = 8'(g);
        b_mean_i     = 8'(b);
        mean_valid_i = 1'b1;
        step();
        mean_valid_i = 1'b0;
    endtask

    // counts busy cycles after the strobe edge, bounded
    task automatic count_busy(output int n);
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic pixel(input int c, input int v, input bit l);
        valid_i = 1'b1;
        color_i = 2'(c);
        value_i = 8'(v);
        last_i  = l;
        step();
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    initial begin
        int n;
        // gains R=128, B=255
        vecs[0]  = '{2'd0, 8'd100, 1'b0, 8'd200};
        vecs[1]  = '{2'd0, 8'd200, 1'b0, 8'd255};
        vecs[2]  = '{2'd2, 8'd10,  1'b0, 8'd40};
        vecs[3]  = '{2'd1, 8'd77,  1'b0, 8'd77};
        vecs[4]  = '{2'd3, 8'd200, 1'b0, 8'd200};
        vecs[5]  = '{2'd0, 8'd0,   1'b0, 8'd0};
        vecs[6]  = '{2'd2, 8'd1,   1'b0, 8'd4};
        vecs[7]  = '{2'd2, 8'd255, 1'b0, 8'd255};
        vecs[8]  = '{2'd0, 8'd1,   1'b0, 8'd2};
        vecs[9]  = '{2'd0, 8'd127, 1'b0, 8'd254};
        vecs[10] = '{2'd0, 8'd128, 1'b0, 8'd255};
        vecs[11] = '{2'd3, 8'd255, 1'b1, 8'd255};

        rst_n = 1'b0;
        mean_valid_i = 1'b0; r_mean_i = '0; g_mean_i = '0; b_mean_i = '0;
        valid_i = 1'b0; color_i = '0; value_i = '0; last_i = 1'b0;
        step(); step();
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_gain_r", gain_r_o, 64);
        chk("rst_gain_b", gain_b_o, 64);
        chk("rst_value", value_o, 0);
        rst_n = 1'b1;
        step();

        // r=64 g=128 b=32 -> 128 / 256 saturated to 255
        strobe(64, 128, 32);
        count_busy(n);
        chk("busy_cycles_1", n, 29);
        chk("gain_r_before_commit", gain_r_o, 64);
        step();
        chk("gain_r_1", gain_r_o, 128);
        chk("gain_b_1", gain_b_o, 255);

        foreach (vecs[i]) begin
            pixel(vecs[i].color, vecs[i].value, vecs[i].last);
            chk("lat_not_1", valid_o, 0);
            step();
            chk("vec_valid", valid_o, 1);
            chk("vec_color", color_o, vecs[i].color);
            chk("vec_last", last_o, vecs[i].last);
            chk($sformatf("vec_value[%0d]", i), value_o, vecs[i].exp);
            step();
            chk("vec_valid_drop", valid_o, 0);
            chk("vec_value_hold", value_o, vecs[i].exp);
        end

        // zero red divisor -> max gain; blue 50/50 -> unity
        strobe(0, 50, 50);
        count_busy(n);
        chk("busy_cycles_zero", n, 29);
        step();
        chk("gain_r_zero", gain_r_o, 255);
        chk("gain_b_zero", gain_b_o, 64);

        // strobe mid-frame: pixels keep old gain 255 (20 -> 80); new r=32 b=16 after frame end
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                r_mean_i = 8'd100; g_mean_i = 8'd50; b_mean_i = 8'd200;
                mean_valid_i = 1'b1;
            end
            pixel(0, 20, k == 9);
            mean_valid_i = 1'b0;
            if (k == 9) begin
                chk("gain_r_at_frame_end", gain_r_o, 255);
                chk("busy_done_before_end", busy_o, 0);
            end
            step();
            chk($sformatf("frame_px[%0d]", k), value_o, 80);
            if (k == 9) begin
                chk("frame_last_o", last_o, 1);
                chk("gain_r_commit", gain_r_o, 32);
                chk("gain_b_commit", gain_b_o, 16);
            end else begin
                repeat (4) step();
            end
        end
        pixel(0, 20, 1'b1);
        step();
        chk("px_new_gain", value_o, 10);

        // second strobe while busy is dropped
        strobe(64, 128, 32);
        repeat (5) step();
        strobe(32, 32, 32);
        n = 0;
        while (busy_o && n < 100) begin n++; step(); end
        chk("busy_cycles_drop", n, 23);
        step();
        chk("gain_r_drop", gain_r_o, 128);
        chk("gain_b_drop", gain_b_o, 255);

        // reset in the middle of DIV_B aborts everything
        strobe(32, 128, 64);
        repeat (17) step();
        pixel(0, 100, 1'b0);
        step();
        chk("pre_rst_busy", busy_o, 1);
        chk("pre_rst_valid", valid_o, 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_gain_r", gain_r_o, 64);
        chk("mid_rst_gain_b", gain_b_o, 64);
        chk("mid_rst_valid", valid_o, 0);
        step();
        rst_n = 1'b1;
        repeat (40) step();
        chk("post_rst_gain_r", gain_r_o, 64);
        chk("post_rst_gain_b", gain_b_o, 64);
        chk("post_rst_busy", busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
